irq_collector: RTL and testbench
================================

// Module: irq_collector
// PURPOSE
//  Front end for the CP0 interrupt cause logic. Brings 30 asynchronous device IRQ lines into clk.
//  Per line, it synchronises, optionally glitch-filters, classifies as edge or level, and applies masking.
//  It then drives ir_map[30:1], which CP0 ORs into ICR every cycle.
//  CP0 bit 0 (timer) is excluded; bit 31 (global enable) stays in CP0.
// PARAMETERS
//  EDGE_MASK      30'h0   per line: 1 = rising-edge triggered, 0 = level triggered (bit i-1 -> line i)
//  SYNC_STAGES    2       synchroniser depth, legal range 2..4
//  FILTER_CYCLES  16      consecutive cycles a changed level must persist (only with IRQ_FILTER_EN)
// PORTS
//  clk          in   1   main clock
//  rst_n        in   1   synchronous reset, active low
//  irq_in       in   30  raw device IRQ lines [30:1], asynchronous to clk, active high
//  irq_mask     in   30  [30:1], 1 = line masked (suppressed at output, edges held pending)
//  lost_clr     in   30  [30:1], 1-cycle write pulse, clears the matching lost bits
//  ir_map       out  30  [30:1], registered, to CP0 ir_map
//  irq_level    out  30  [30:1], conditioned (synced/filtered) level, for debug/status read
//  irq_lost     out  30  [30:1], sticky: an edge merged/dropped while pending
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): all sync flops, filter state, prev-level, pending, ir_map, irq_level, irq_lost <= 0.
//  - Sync: irq_in passes through SYNC_STAGES flops. Nothing is combinational from irq_in to any output.
//  - Conditioned level L = last sync stage; with the filter enabled, L = filtered level.
//  - Latency, no filter, SYNC_STAGES=2, edge line unmasked:
//    irq_in high before edge k gives ir_map high after edge k+2, for exactly 1 cycle.
//  - Edge line: rise = L & ~L_prev (L_prev registered).
//    Unmasked: ir_map[i] <= rise.
//    Masked: rise sets pending[i]; ir_map[i] <= 0.
//  - Release: in the cycle mask[i]==0 and pending[i]==1, ir_map[i] <= 1 for one cycle and pending[i] <= 0.
//  - Simultaneous release and new rise: single 1-cycle pulse; irq_lost[i] <= 1.
//  - Rise while pending already set: pending stays 1; irq_lost[i] <= 1.
//  - Level line: ir_map[i] <= L & ~mask[i]; pending/lost never set.
//  - Line high at reset exit: L_prev=0, so an edge line generates one pulse after sync latency.
//  - lost_clr[i] and a new loss in the same cycle: set wins (bit stays 1).
//  - Mask changes take effect on the next posedge. There is no handshake; CP0 samples ir_map every cycle.
//  - Reset mid-operation clears pending events without a pulse; in-flight sync bits are discarded.
// CONFIGURATION
//  IRQ_FILTER_EN defined: per line, a counter of width GET_WIDTH(FILTER_CYCLES) runs while
//    sync_out != L and clears when they agree.
//    When the count reaches FILTER_CYCLES-1 with sync_out still != L, L <= sync_out and the counter clears.
//    Glitches shorter than FILTER_CYCLES cycles never reach L.
//    Latency grows by FILTER_CYCLES cycles.
//  IRQ_FILTER_EN undefined: no counters; L = sync_out; FILTER_CYCLES ignored.
// STRUCTURE
//  - Shared headers: IRQ_LINES=30 and IRQ_LINE_LO=1 go in mips_define.vh; GET_WIDTH comes from function.vh.
//  - Sub-module irq_line: one line (sync chain, optional filter, edge/level, pending, lost).
//    It has parameters IS_EDGE, SYNC_STAGES, FILTER_CYCLES.
//    Top instantiates 30 copies in a generate loop, wiring EDGE_MASK[i-1] to IS_EDGE.
// TESTING
//  1 Edge line 5, unmasked, no filter: irq_in[5]=1 at cycle 10 -> ir_map[5]=1 only in cycle 12; held high -> no more pulses.
//  2 Edge line 5 masked: rise at cycle 10; unmask at cycle 20 -> one pulse at cycle 21, pending clears.
//    Second rise before unmask -> irq_lost[5]=1; lost_clr[5] -> 0 next cycle.
//  3 Level line 7 (EDGE_MASK[6]=0): irq_in[7]=1 for 50 cycles -> ir_map[7] high for 50 cycles, delayed 2.
//    mask[7]=1 mid-way -> ir_map[7]=0 next cycle.
//  4 IRQ_FILTER_EN, FILTER_CYCLES=16: 15-cycle pulse on line 3 -> ir_map[3] never set.
//    20-cycle pulse -> exactly one ir_map[3] pulse, 16 cycles later than in test 1.
//  5 rst_n=0 for 1 cycle while pending[5]=1 and sync carries a rise -> no pulse, irq_lost=0.
//    With the line held high after reset -> exactly one pulse.
//  6 All 30 edge lines rise in the same cycle -> ir_map=30'h3FFFFFFF for one cycle; irq_lost stays 0.

Source files
------------

// File: rtl/irq_collector_pkg.sv
// Shared constants for the CP0 interrupt front end: line numbering and a width helper.
// Build option IRQ_FILTER_EN (glitch filter) is consumed by irq_line.
package irq_collector_pkg;

  localparam int IRQ_LINES   = 30;
  localparam int IRQ_LINE_LO = 1;
  localparam int IRQ_LINE_HI = IRQ_LINE_LO + IRQ_LINES - 1;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int get_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/irq_line.sv
// One IRQ line: synchroniser, optional glitch filter (IRQ_FILTER_EN), edge/level classify, pending, lost.
// Output is registered; sync latency SYNC_STAGES cycles (+FILTER_CYCLES with the filter), no backpressure.
module irq_line
  import irq_collector_pkg::*;
#(
  parameter bit IS_EDGE       = 1'b0,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_i,
  input  logic mask_i,
  input  logic lost_clr_i,
  output logic ir_map_o,
  output logic level_o,
  output logic lost_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   lvl;
  logic                   lprev_q;
  logic                   pend_q, pend_d;
  logic                   map_q, map_d;
  logic                   lost_q, lost_d;
  logic                   rise;

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef IRQ_FILTER_EN
  localparam int CW = get_width(FILTER_CYCLES);
  logic [CW-1:0] cnt_q;
  logic          lvl_q;

  // A changed level is only accepted after FILTER_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else if (sync_out != lvl_q) begin
      if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
        lvl_q <= sync_out;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign lvl = lvl_q;
`else
  assign lvl = sync_out;
`endif

  assign rise = lvl & ~lprev_q;

  always_comb begin
    map_d  = 1'b0;
    pend_d = 1'b0;
    lost_d = lost_q & ~lost_clr_i;
    if (IS_EDGE) begin
      // A rise landing on an already-pending event is merged into it and flagged.
      map_d  = ~mask_i & (rise | pend_q);
      pend_d = mask_i & (rise | pend_q);
      if (rise && pend_q) lost_d = 1'b1;
    end else begin
      map_d = lvl & ~mask_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      lprev_q <= 1'b0;
      pend_q  <= 1'b0;
      map_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], irq_i};
      lprev_q <= lvl;
      pend_q  <= pend_d;
      map_q   <= map_d;
      lost_q  <= lost_d;
    end
  end

  assign ir_map_o = map_q;
  assign level_o  = lvl;
  assign lost_o   = lost_q;

endmodule

// File: rtl/irq_collector.sv
// Conditions 30 async device IRQs [30:1] into registered ir_map for CP0; no handshake, sampled every cycle.
// Build option IRQ_FILTER_EN adds a per-line glitch filter of FILTER_CYCLES cycles.
module irq_collector
  import irq_collector_pkg::*;
#(
  parameter logic [IRQ_LINES-1:0] EDGE_MASK = '0,
  parameter int                   SYNC_STAGES   = 2,
  parameter int                   FILTER_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [IRQ_LINE_HI:IRQ_LINE_LO] irq_in,
  input  logic [IRQ_LINE_HI:IRQ_LINE_LO] irq_mask,
  input  logic [IRQ_LINE_HI:IRQ_LINE_LO] lost_clr,
  output logic [IRQ_LINE_HI:IRQ_LINE_LO] ir_map,
  output logic [IRQ_LINE_HI:IRQ_LINE_LO] irq_level,
  output logic [IRQ_LINE_HI:IRQ_LINE_LO] irq_lost
);

  for (genvar i = IRQ_LINE_LO; i <= IRQ_LINE_HI; i++) begin : g_line
    irq_line #(
      .IS_EDGE      (EDGE_MASK[i-IRQ_LINE_LO]),
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_line (
      .clk       (clk),
      .rst_n     (rst_n),
      .irq_i     (irq_in[i]),
      .mask_i    (irq_mask[i]),
      .lost_clr_i(lost_clr[i]),
      .ir_map_o  (ir_map[i]),
      .level_o   (irq_level[i]),
      .lost_o    (irq_lost[i])
    );
  end

endmodule

// File: tb/tb_irq_collector.sv
// Directed bench for irq_collector: every line edge-triggered except line 7 (level).
module tb_irq_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [30:1] irq_in, irq_mask, lost_clr;
  logic [30:1] ir_map, irq_level, irq_lost;
  int          n_chk = 0;
  int          n_bad = 0;

`ifdef IRQ_FILTER_EN
  localparam int LAT = 19;
`else
  localparam int LAT = 3;
`endif

  always #5 clk = ~clk;

  irq_collector #(
    .EDGE_MASK    (30'h3FFF_FFBF),
    .SYNC_STAGES  (2),
    .FILTER_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_in   (irq_in),
    .irq_mask (irq_mask),
    .lost_clr (lost_clr),
    .ir_map   (ir_map),
    .irq_level(irq_level),
    .irq_lost (irq_lost)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; irq_in = '0; irq_mask = '0; lost_clr = '0;
    repeat (3) step();
    n_chk++; if (ir_map !== 30'h0)    begin n_bad++; $display("FAIL reset_map got=%h want=0", ir_map); end
    n_chk++; if (irq_level !== 30'h0) begin n_bad++; $display("FAIL reset_level got=%h want=0", irq_level); end
    n_chk++; if (irq_lost !== 30'h0)  begin n_bad++; $display("FAIL reset_lost got=%h want=0", irq_lost); end
    rst_n = 1'b1;
    step();
    n_chk++; if (ir_map !== 30'h0)    begin n_bad++; $display("FAIL reset_exit_map got=%h want=0", ir_map); end
  endtask

  task automatic test_edge_unmasked();
    irq_in[5] = 1'b1;
    for (int s = 1; s <= LAT + 8; s++) begin
      step();
      n_chk++;
      if (ir_map[5] !== (s == LAT)) begin
        n_bad++; $display("FAIL edge5_step%0d got=%b want=%b", s, ir_map[5], (s == LAT));
      end
      if (s == LAT - 1) begin
        n_chk++;
        if (irq_level[5] !== 1'b1) begin n_bad++; $display("FAIL edge5_level got=%b want=1", irq_level[5]); end
      end
    end
    irq_in[5] = 1'b0;
    repeat (LAT + 4) step();
  endtask

  task automatic test_masked_pending();
    irq_mask[5] = 1'b1; irq_in[5] = 1'b1;
    for (int s = 1; s <= LAT + 3; s++) begin
      step();
      n_chk++;
      if (ir_map[5] !== 1'b0) begin n_bad++; $display("FAIL masked5_step%0d got=%b want=0", s, ir_map[5]); end
    end
    n_chk++; if (irq_lost[5] !== 1'b0) begin n_bad++; $display("FAIL masked5_nolost got=%b want=0", irq_lost[5]); end
    irq_in[5] = 1'b0; repeat (LAT + 2) step();
    irq_in[5] = 1'b1; repeat (LAT + 2) step();
    n_chk++; if (irq_lost[5] !== 1'b1) begin n_bad++; $display("FAIL masked5_lost got=%b want=1", irq_lost[5]); end
    irq_mask[5] = 1'b0;
    step();
    n_chk++; if (ir_map[5] !== 1'b1) begin n_bad++; $display("FAIL release5_pulse got=%b want=1", ir_map[5]); end
    for (int s = 1; s <= 4; s++) begin
      step();
      n_chk++;
      if (ir_map[5] !== 1'b0) begin n_bad++; $display("FAIL release5_after%0d got=%b want=0", s, ir_map[5]); end
    end
    n_chk++; if (irq_lost[5] !== 1'b1) begin n_bad++; $display("FAIL lost5_sticky got=%b want=1", irq_lost[5]); end
    lost_clr[5] = 1'b1; step(); lost_clr[5] = 1'b0;
    n_chk++; if (irq_lost[5] !== 1'b0) begin n_bad++; $display("FAIL lost5_clr got=%b want=0", irq_lost[5]); end
    irq_in[5] = 1'b0;
    repeat (LAT + 2) step();
  endtask

  task automatic test_release_collision();
    irq_mask[5] = 1'b1; irq_in[5] = 1'b1;
    repeat (LAT + 2) step();
    irq_in[5] = 1'b0;
    repeat (LAT + 2) step();
    n_chk++; if (irq_lost[5] !== 1'b0) begin n_bad++; $display("FAIL coll5_prelost got=%b want=0", irq_lost[5]); end
    irq_in[5] = 1'b1;
    repeat (LAT - 1) step();
    // Unmask and clear-lost in the very cycle the new rise is seen.
    irq_mask[5] = 1'b0; lost_clr[5] = 1'b1;
    step();
    lost_clr[5] = 1'b0;
    n_chk++; if (ir_map[5] !== 1'b1)   begin n_bad++; $display("FAIL coll5_pulse got=%b want=1", ir_map[5]); end
    n_chk++; if (irq_lost[5] !== 1'b1) begin n_bad++; $display("FAIL coll5_lost got=%b want=1", irq_lost[5]); end
    for (int s = 1; s <= 4; s++) begin
      step();
      n_chk++;
      if (ir_map[5] !== 1'b0) begin n_bad++; $display("FAIL coll5_after%0d got=%b want=0", s, ir_map[5]); end
    end
    lost_clr[5] = 1'b1; step(); lost_clr[5] = 1'b0;
    irq_in[5] = 1'b0;
    repeat (LAT + 2) step();
  endtask

  task automatic test_level();
    logic exp;
    irq_in[7] = 1'b1;
    for (int s = 1; s <= LAT + 53; s++) begin
      step();
      exp = (s >= LAT) && (s <= LAT + 49) && (s <= 30);
      n_chk++;
      if (ir_map[7] !== exp) begin n_bad++; $display("FAIL level7_step%0d got=%b want=%b", s, ir_map[7], exp); end
      if (s == 30) irq_mask[7] = 1'b1;
      if (s == 50) irq_in[7] = 1'b0;
    end
    n_chk++; if (irq_lost[7] !== 1'b0) begin n_bad++; $display("FAIL level7_lost got=%b want=0", irq_lost[7]); end
    irq_mask[7] = 1'b0;
    step();
    n_chk++; if (ir_map[7] !== 1'b0) begin n_bad++; $display("FAIL level7_unmask_low got=%b want=0", ir_map[7]); end
  endtask

  task automatic test_reset_mid();
    irq_mask[5] = 1'b1; irq_in[5] = 1'b1;
    repeat (LAT + 2) step();
    irq_in[5] = 1'b0;
    repeat (LAT + 2) step();
    irq_in[5] = 1'b1;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; irq_mask[5] = 1'b0;
    for (int s = 1; s <= LAT + 6; s++) begin
      step();
      n_chk++;
      if (ir_map[5] !== (s == LAT)) begin
        n_bad++; $display("FAIL rstmid5_step%0d got=%b want=%b", s, ir_map[5], (s == LAT));
      end
      n_chk++;
      if (irq_lost[5] !== 1'b0) begin n_bad++; $display("FAIL rstmid5_lost%0d got=%b want=0", s, irq_lost[5]); end
    end
    irq_in[5] = 1'b0;
    repeat (LAT + 2) step();
  endtask

  task automatic test_all_lines();
    logic [30:1] exp;
    irq_in = '1;
    for (int s = 1; s <= LAT + 3; s++) begin
      step();
      exp = (s == LAT) ? 30'h3FFF_FFFF : (s > LAT) ? 30'h0000_0040 : 30'h0;
      n_chk++;
      if (ir_map !== exp) begin n_bad++; $display("FAIL all_step%0d got=%h want=%h", s, ir_map, exp); end
    end
    n_chk++; if (irq_lost !== 30'h0) begin n_bad++; $display("FAIL all_lost got=%h want=0", irq_lost); end
    irq_in = '0;
    repeat (LAT + 3) step();
    n_chk++; if (ir_map !== 30'h0) begin n_bad++; $display("FAIL all_idle got=%h want=0", ir_map); end
  endtask

`ifdef IRQ_FILTER_EN
  task automatic test_filter();
    irq_in[3] = 1'b1;
    repeat (15) step();
    irq_in[3] = 1'b0;
    for (int s = 1; s <= 40; s++) begin
      step();
      n_chk++;
      if (ir_map[3] !== 1'b0 || irq_level[3] !== 1'b0) begin
        n_bad++; $display("FAIL glitch3_step%0d map=%b lvl=%b want=0", s, ir_map[3], irq_level[3]);
      end
    end
    irq_in[3] = 1'b1;
    for (int s = 1; s <= 45; s++) begin
      step();
      n_chk++;
      if (ir_map[3] !== (s == LAT)) begin
        n_bad++; $display("FAIL filt3_step%0d got=%b want=%b", s, ir_map[3], (s == LAT));
      end
      if (s == 20) irq_in[3] = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_edge_unmasked();
    test_masked_pending();
    test_release_collision();
    test_level();
    test_reset_mid();
    test_all_lines();
`ifdef IRQ_FILTER_EN
    test_filter();
`endif
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
